serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised bit-serial subtractor computing `a - b - bin` over `WIDTH` bits using one full-subtractor cell and a registered borrow, LSB first, one bit per clock. It is the sequential successor of the single-bit full subtractor in the combinational library. It suits datapaths that trade latency for area. A start/busy/done handshake wraps the operation, and the block also reports final unsigned borrow and signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only when not busy.
- `a`  in  WIDTH: minuend; captured on the accepting edge.
- `b`  in  WIDTH: subtrahend; captured on the accepting edge.
- `bin`  in  1: borrow-in; captured on the accepting edge.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: single-cycle pulse; the result became valid on this cycle.
- `diff`  out  WIDTH: registered result `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: final borrow; equals 1 when `a < b + bin` (unsigned).
- `ovf`  out  1: two's-complement overflow of the signed subtraction.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE or DONE, with `start`=1:**
  - Load `a`, `b` into shift registers.
  - Load the borrow register with `bin`.
  - Set the bit counter to 0.
  - Go to RUN.
- **IDLE or DONE, with `start`=0:**
  - DONE moves to IDLE.
  - IDLE holds.
- **RUN, each edge:**
  - The cell takes LSBs `x`, `y` and borrow `br`.
  - `d = x ^ y ^ br`.
  - `bo = (~x & y) | (~(x ^ y) & br)`.
  - `d` shifts into the MSB of the internal difference register; both operand registers shift right.
  - `br <= bo`; counter increments.
- **RUN, on the edge processing bit WIDTH-1:**
  - Load the output registers.
  - `diff` = final difference register.
  - `bout` = `bo`.
  - `ovf` = `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operand MSBs.
  - Go to DONE.
- **Output registers:** `diff`, `bout`, `ovf` change only on the completion edge. They hold their previous values during RUN and until the next completion.
- **`start` while RUN:** ignored; no queueing.
- **Operand changes after acceptance:** no effect on the operation in flight.
- **Counter:** `$clog2(WIDTH)` bits; it never wraps because RUN exits at `WIDTH-1`.

## Timing
- **Reset:**
  - Asserting `rst` at any time, including mid-RUN, forces state IDLE.
  - All outputs go to 0: `busy`, `done`, `diff`, `bout`, `ovf`.
  - The internal shift registers, borrow register and counter go to 0.
  - An aborted operation produces no `done`.
  - The first accepting edge after `rst` deasserts starts a clean operation.
- **`busy`:** registered; equals (state == RUN). It rises the cycle after the accepting edge E and stays high for exactly WIDTH cycles.
- **`done`:** registered; equals (state == DONE). It is high for exactly the one cycle following edge E+WIDTH, and outputs are valid in that same cycle.
- **Latency:** WIDTH clocks from the accepting edge to results being valid.
- **Back-to-back operation:**
  - A `start` in the `done` cycle is accepted.
  - The next `busy` begins the following cycle, giving a throughput of one operation per WIDTH+1 cycles.
- **Outputs:** no combinational path from inputs to outputs.

## Structure
- **Package `serial_sub_pkg`:** state enum (IDLE, RUN, DONE) and default `WIDTH` constant.
- **Sub-module `full_sub_cell`:** purely combinational. Inputs `a`, `b`, `cin`; outputs `D`, `B`. It carries the equations above and is instantiated once.
- **Top level:** FSM, counter, shift registers, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8 unless stated.
- `a`=0x05, `b`=0x03, `bin`=0 → `diff`=0x02, `bout`=0, `ovf`=0. `done` is high exactly one cycle, 8 clocks after the accepting edge; `busy` is high for 8 cycles.
- `a`=0x03, `b`=0x05, `bin`=0 → `diff`=0xFE, `bout`=1, `ovf`=0. Separately, `a`=0x00, `b`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1, `ovf`=0.
- `a`=0x80, `b`=0x01 → `diff`=0x7F, `bout`=0, `ovf`=1. Separately, `a`=0x7F, `b`=0xFF → `diff`=0x80, `bout`=1, `ovf`=1.
- `start` pulsed with new operands mid-RUN → ignored, and the first result is unchanged. `start` asserted in the `done` cycle → accepted, and the second result is correct 8 clocks later.
- `rst` asserted at bit 4 of a run → all outputs read 0 immediately and no `done` occurs. The next operation 0x10 − 0x01 gives `diff`=0x0F.
- WIDTH=2, exhaustive over all `a`, `b`, `bin` (32 cases) against a reference model of `a − b − bin` → `diff`, `bout` and `ovf` match in every case.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: D = a - b - cin, B = borrow out. Purely combinational.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic D,
  output logic B
);
  assign D = a ^ b ^ cin;
  assign B = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first; results valid WIDTH clocks after the accepting edge.
// No backpressure: start is only sampled when not busy, and done is a single-cycle pulse.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             cell_d, cell_b;

  full_sub_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .cin(br_q),
    .D  (cell_d),
    .B  (cell_b)
  );

  // The minuend register doubles as the difference register: each consumed
  // LSB frees the MSB slot that receives the new difference bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d  = {cell_d, a_q[WIDTH-1:1]};
        b_d  = {1'b0, b_q[WIDTH-1:1]};
        br_d = cell_b;
        if (cnt_q == LAST) begin
          diff_d  = {cell_d, a_q[WIDTH-1:1]};
          bout_d  = cell_b;
          ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vectors plus an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       bin2 = 1'b0;
  logic       busy2, done2, bout2, ovf2;
  logic [1:0] diff2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
  endtask

  // n counts rising edges since the accepting edge, sampled mid-cycle.
  task automatic observe(input bit stop_on_done, input bit poke,
                         output int busy_cnt, output int done_at, output int done_cnt);
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      start = poke && (n == 3);
      if (poke && n == 3) begin a = 8'hAA; b = 8'h11; bin = 1'b1; end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
        if (stop_on_done) return;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] ed, input logic eb, input logic eo,
                          input int busy_cnt, input int done_at, input int done_cnt);
    chk({tag, ".busy_cycles"}, busy_cnt, 8);
    chk({tag, ".done_latency"}, done_at, 8);
    chk({tag, ".done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int bc, da, dc;
    bit seen;
    int sa, sb, res;
    logic [1:0] ed2;
    logic eb2, eo2;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.bout", bout, 0);
    chk("rst.ovf",  ovf,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    launch(8'h05, 8'h03, 1'b0);
    observe(1'b0, 1'b0, bc, da, dc);
    check_op("5m3", 8'h02, 0, 0, bc, da, dc);
    chk("5m3.diff", diff, 8'h02); chk("5m3.bout", bout, 0); chk("5m3.ovf", ovf, 0);

    launch(8'h03, 8'h05, 1'b0);
    observe(1'b0, 1'b0, bc, da, dc);
    chk("3m5.diff", diff, 8'hFE); chk("3m5.bout", bout, 1); chk("3m5.ovf", ovf, 0);
    chk("3m5.done_latency", da, 8);

    launch(8'h00, 8'h00, 1'b1);
    observe(1'b0, 1'b0, bc, da, dc);
    chk("0m0b1.diff", diff, 8'hFF); chk("0m0b1.bout", bout, 1); chk("0m0b1.ovf", ovf, 0);

    launch(8'h80, 8'h01, 1'b0);
    observe(1'b0, 1'b0, bc, da, dc);
    chk("80m01.diff", diff, 8'h7F); chk("80m01.bout", bout, 0); chk("80m01.ovf", ovf, 1);

    // Mid-run start must be ignored; then a start in the done cycle is taken.
    launch(8'h05, 8'h03, 1'b0);
    observe(1'b1, 1'b1, bc, da, dc);
    check_op("midrun", 8'h02, 0, 0, bc, da, dc);
    chk("midrun.diff", diff, 8'h02); chk("midrun.bout", bout, 0); chk("midrun.ovf", ovf, 0);
    launch(8'h7F, 8'hFF, 1'b0);
    chk("b2b.busy_next", busy, 1);
    chk("b2b.hold_diff", diff, 8'h02);
    observe(1'b0, 1'b0, bc, da, dc);
    check_op("b2b", 8'h80, 1, 1, bc, da, dc);
    chk("7Fm FF.diff", diff, 8'h80); chk("7FmFF.bout", bout, 1); chk("7FmFF.ovf", ovf, 1);

    // Abort a run after four bits have been processed.
    launch(8'h33, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort.busy", busy, 0); chk("abort.done", done, 0);
    chk("abort.diff", diff, 0); chk("abort.bout", bout, 0); chk("abort.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    observe(1'b0, 1'b0, bc, da, dc);
    chk("abort.no_done", dc, 0);
    chk("abort.no_busy", bc, 0);
    launch(8'h10, 8'h01, 1'b0);
    observe(1'b0, 1'b0, bc, da, dc);
    check_op("postrst", 8'h0F, 0, 0, bc, da, dc);
    chk("postrst.diff", diff, 8'h0F); chk("postrst.bout", bout, 0); chk("postrst.ovf", ovf, 0);

    // WIDTH=2 exhaustive against an arithmetic reference.
    for (int i = 0; i < 32; i++) begin
      a2 = i[4:3]; b2 = i[2:1]; bin2 = i[0]; start2 = 1'b1;
      sa = a2[1] ? int'(a2) - 4 : int'(a2);
      sb = b2[1] ? int'(b2) - 4 : int'(b2);
      res = sa - sb - int'(bin2);
      ed2 = 2'(int'(a2) - int'(b2) - int'(bin2));
      eb2 = (int'(a2) < int'(b2) + int'(bin2));
      eo2 = (res < -2) || (res > 1);
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        if (done2) seen = 1'b1;
        else @(negedge clk);
      end
      chk($sformatf("w2[%0d].done", i), seen, 1);
      chk($sformatf("w2[%0d].diff", i), diff2, ed2);
      chk($sformatf("w2[%0d].bout", i), bout2, eb2);
      chk($sformatf("w2[%0d].ovf", i), ovf2, eo2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
